// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the icache/dcache memory-port arbiter.
package mem_arb_pkg;

  localparam int unsigned XLEN                 = 32;
  localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StGntI = 2'd1,
    StGntD = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one unified memory port between instruction fetch and load/store traffic.
// Data side wins ties; a bounded streak counter guarantees fetch forward progress.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            icache_en,
  input  logic [XLEN-1:0] icache_addr,
  output logic [XLEN-1:0] icache_data,
  output logic            icache_rdy,
  input  logic            dcache_en,
  input  logic            dcache_wr,
  input  logic [XLEN-1:0] dcache_addr,
  input  logic [XLEN-1:0] dcache_wdata,
  output logic [XLEN-1:0] dcache_rdata,
  output logic            dcache_rdy,
  output logic            mem_en,
  output logic            mem_wr,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_rdy
);

  localparam logic [3:0] StreakMax = 4'(STARVE_LIMIT);

  arb_state_e      state_q;
  logic [3:0]      dstreak_q, dstreak_d;
  logic            icache_rdy_q, dcache_rdy_q;
  logic [XLEN-1:0] icache_data_q, dcache_rdata_q;
  logic            mem_en_q, mem_wr_q;
  logic [XLEN-1:0] mem_addr_q, mem_wdata_q;

  logic icache_live, dcache_live;
  logic grant_i, grant_d;

  // A requester still holding en during its own completion cycle must not re-win.
  assign icache_live = icache_en & ~icache_rdy_q;
  assign dcache_live = dcache_en & ~dcache_rdy_q;

  always_comb begin
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    dstreak_d = dstreak_q;
    if (state_q == StIdle) begin
      if (dcache_live && !(icache_live && (dstreak_q == StreakMax))) begin
        grant_d = 1'b1;
      end else if (icache_live) begin
        grant_i = 1'b1;
      end
    end
    if (grant_i) begin
      dstreak_d = 4'd0;
    end else if (grant_d && icache_live && (dstreak_q != StreakMax)) begin
      dstreak_d = dstreak_q + 4'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      dstreak_q      <= 4'd0;
      icache_rdy_q   <= 1'b0;
      dcache_rdy_q   <= 1'b0;
      icache_data_q  <= '0;
      dcache_rdata_q <= '0;
      mem_en_q       <= 1'b0;
      mem_wr_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
    end else begin
      icache_rdy_q <= 1'b0;
      dcache_rdy_q <= 1'b0;
      dstreak_q    <= dstreak_d;
      unique case (state_q)
        StIdle: begin
          if (grant_d) begin
            state_q     <= StGntD;
            mem_en_q    <= 1'b1;
            mem_wr_q    <= dcache_wr;
            mem_addr_q  <= dcache_addr;
            mem_wdata_q <= dcache_wdata;
          end else if (grant_i) begin
            state_q     <= StGntI;
            mem_en_q    <= 1'b1;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= icache_addr;
            mem_wdata_q <= '0;
          end
        end
        StGntI: begin
          if (mem_rdy) begin
            state_q       <= StIdle;
            mem_en_q      <= 1'b0;
            icache_rdy_q  <= 1'b1;
            icache_data_q <= mem_rdata;
          end
        end
        StGntD: begin
          if (mem_rdy) begin
            state_q      <= StIdle;
            mem_en_q     <= 1'b0;
            dcache_rdy_q <= 1'b1;
            // Stores leave the last load result visible.
            if (!mem_wr_q) begin
              dcache_rdata_q <= mem_rdata;
            end
          end
        end
        default: begin
          state_q  <= StIdle;
          mem_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign icache_data  = icache_data_q;
  assign icache_rdy   = icache_rdy_q;
  assign dcache_rdata = dcache_rdata_q;
  assign dcache_rdy   = dcache_rdy_q;
  assign mem_en       = mem_en_q;
  assign mem_wr       = mem_wr_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected grants and completions,
// a monitor process checks them as the DUT presents mem_en and rdy pulses.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ireq = 1'b0, dreq = 1'b0, yield = 1'b0;
  logic        icache_en, dcache_en;
  logic [31:0] icache_addr = '0;
  logic        dcache_wr = 1'b0;
  logic [31:0] dcache_addr = '0, dcache_wdata = '0;
  logic [31:0] icache_data, dcache_rdata;
  logic        icache_rdy, dcache_rdy;
  logic        mem_en, mem_wr, mem_rdy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clock = ~clock;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .icache_en    (icache_en),
    .icache_addr  (icache_addr),
    .icache_data  (icache_data),
    .icache_rdy   (icache_rdy),
    .dcache_en    (dcache_en),
    .dcache_wr    (dcache_wr),
    .dcache_addr  (dcache_addr),
    .dcache_wdata (dcache_wdata),
    .dcache_rdata (dcache_rdata),
    .dcache_rdy   (dcache_rdy),
    .mem_en       (mem_en),
    .mem_wr       (mem_wr),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_rdy      (mem_rdy)
  );

  // With yield set, both requesters sit out any completion cycle so every grant is a race.
  assign icache_en = ireq & ~(yield & (icache_rdy | dcache_rdy));
  assign dcache_en = dreq & ~(yield & (icache_rdy | dcache_rdy));

  // Memory model: 16 words indexed by addr[11:8], programmable wait cycles.
  logic [31:0] mem_model [16];
  logic        init_mem = 1'b1;
  int          mem_wait = 0;
  int          wcnt = 0;
  int          cyc = 0;

  assign mem_rdy   = mem_en && (wcnt == mem_wait);
  assign mem_rdata = mem_wr ? 32'hFFFF_FFFF : mem_model[mem_addr[11:8]];

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (init_mem) begin
      for (int i = 0; i < 16; i++) mem_model[i] <= 32'h0BAD_0000 | 32'(i);
      mem_model[1] <= 32'hDEAD_BEEF;
      mem_model[3] <= 32'h1111_1111;
      mem_model[4] <= 32'h4444_0004;
      mem_model[6] <= 32'h6666_0006;
      mem_model[7] <= 32'h7777_0007;
      mem_model[8] <= 32'h2222_2222;
    end else if (mem_en && mem_rdy && mem_wr) begin
      mem_model[mem_addr[11:8]] <= mem_wdata;
    end
    if (!mem_en || mem_rdy) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    int          due;
  } gnt_t;

  typedef struct {
    logic        side_d;
    logic [31:0] data;
    int          due;
  } rsp_t;

  gnt_t gq[$];
  rsp_t rq[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_gnt(input logic [31:0] a, input logic w, input logic [31:0] wd,
                         input int due);
    gnt_t g;
    g.addr = a; g.wr = w; g.wdata = wd; g.due = due;
    gq.push_back(g);
  endtask

  task automatic exp_rsp(input logic side_d, input logic [31:0] d, input int due);
    rsp_t r;
    r.side_d = side_d; r.data = d; r.due = due;
    rq.push_back(r);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_rdy(input string name, input logic side_d, input int limit);
    logic got = 1'b0;
    for (int n = 0; n < limit && !got; n++) begin
      step();
      got = side_d ? dcache_rdy : icache_rdy;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: no rdy within %0d cycles", name, limit);
    end
  endtask

  task automatic wait_done(input string name, input int want, input int limit);
    int done = 0;
    for (int n = 0; n < limit && done < want; n++) begin
      step();
      if (icache_rdy || dcache_rdy) done++;
      if (done == want) begin
        ireq = 1'b0;
        dreq = 1'b0;
      end
    end
    if (done < want) begin
      ireq = 1'b0;
      dreq = 1'b0;
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: %0d of %0d completions", name, done, want);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_en"}, 32'(mem_en), 32'h0);
    chk({tag, "_mem_wr"}, 32'(mem_wr), 32'h0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_icache_rdy"}, 32'(icache_rdy), 32'h0);
    chk({tag, "_icache_data"}, icache_data, 32'h0);
    chk({tag, "_dcache_rdy"}, 32'(dcache_rdy), 32'h0);
    chk({tag, "_dcache_rdata"}, dcache_rdata, 32'h0);
  endtask

  // Monitor: pops expectations on every new grant and every completion pulse.
  initial begin
    gnt_t cur;
    rsp_t r;
    logic men_prev = 1'b0;
    cur.addr = '0; cur.wr = 1'b0; cur.wdata = '0; cur.due = -1;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (mem_en && !men_prev) begin
          if (gq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL grant_unexpected: got addr %h expected no grant", mem_addr);
          end else begin
            cur = gq.pop_front();
            chk("grant_addr", mem_addr, cur.addr);
            chk("grant_wr", 32'(mem_wr), 32'(cur.wr));
            chk("grant_wdata", mem_wdata, cur.wdata);
            if (cur.due >= 0) chk("grant_cycle", 32'(cyc), 32'(cur.due));
          end
        end else if (mem_en) begin
          chk("mem_addr_stable", mem_addr, cur.addr);
          chk("mem_wdata_stable", mem_wdata, cur.wdata);
        end
        if (icache_rdy || dcache_rdy) begin
          chk("rdy_exclusive", 32'(icache_rdy & dcache_rdy), 32'h0);
          if (rq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rsp_unexpected: got i=%b d=%b expected no completion",
                     icache_rdy, dcache_rdy);
          end else begin
            r = rq.pop_front();
            chk("rsp_side", 32'(dcache_rdy), 32'(r.side_d));
            chk("rsp_data", dcache_rdy ? dcache_rdata : icache_data, r.data);
            if (r.due >= 0) chk("rsp_cycle", 32'(cyc), 32'(r.due));
          end
        end
      end
      men_prev = mem_en;
    end
  end

  initial begin
    int c0;
    // Power-on reset
    repeat (2) @(posedge clock);
    #1;
    chk_all_zero("por");
    reset = 1'b0;
    init_mem = 1'b0;

    // Lone fetch, zero wait
    step();
    c0 = cyc;
    ireq = 1'b1; icache_addr = 32'h100;
    exp_gnt(32'h100, 1'b0, 32'h0, c0 + 1);
    exp_rsp(1'b0, 32'hDEAD_BEEF, c0 + 2);
    wait_rdy("fetch", 1'b0, 20);
    ireq = 1'b0;

    // Store: dcache_rdata keeps its reset value
    step();
    c0 = cyc;
    dreq = 1'b1; dcache_wr = 1'b1; dcache_addr = 32'h200; dcache_wdata = 32'h55AA;
    exp_gnt(32'h200, 1'b1, 32'h55AA, c0 + 1);
    exp_rsp(1'b1, 32'h0, c0 + 2);
    wait_rdy("store", 1'b1, 20);
    dreq = 1'b0;

    // Load back with three wait cycles
    mem_wait = 3;
    step();
    c0 = cyc;
    dreq = 1'b1; dcache_wr = 1'b0; dcache_wdata = 32'h1234;
    exp_gnt(32'h200, 1'b0, 32'h1234, c0 + 1);
    exp_rsp(1'b1, 32'h55AA, c0 + 5);
    wait_rdy("load", 1'b1, 20);
    dreq = 1'b0;

    // Held enable: no re-grant in the rdy cycle
    mem_wait = 0;
    step();
    c0 = cyc;
    ireq = 1'b1; icache_addr = 32'h300;
    exp_gnt(32'h300, 1'b0, 32'h0, c0 + 1);
    exp_rsp(1'b0, 32'h1111_1111, c0 + 2);
    wait_rdy("held1", 1'b0, 20);
    icache_addr = 32'h800;
    exp_gnt(32'h800, 1'b0, 32'h0, c0 + 4);
    exp_rsp(1'b0, 32'h2222_2222, c0 + 5);
    wait_rdy("held2", 1'b0, 20);
    ireq = 1'b0;

    // Dropped request mid-transaction still completes once
    mem_wait = 3;
    step();
    c0 = cyc;
    ireq = 1'b1; icache_addr = 32'h400;
    exp_gnt(32'h400, 1'b0, 32'h0, c0 + 1);
    exp_rsp(1'b0, 32'h4444_0004, c0 + 5);
    step();
    ireq = 1'b0; icache_addr = 32'hF00;
    wait_rdy("drop", 1'b0, 20);
    step();
    chk("drop_idle_mem_en", 32'(mem_en), 32'h0);

    // Reset while a store waits on memory
    mem_wait = 20;
    step();
    c0 = cyc;
    dreq = 1'b1; dcache_wr = 1'b1; dcache_addr = 32'h500; dcache_wdata = 32'h9999;
    exp_gnt(32'h500, 1'b1, 32'h9999, c0 + 1);
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("async_rst");
    step();
    step();
    dreq = 1'b0; dcache_wr = 1'b0;
    reset = 1'b0;

    // Fresh fetch after reset
    mem_wait = 0;
    step();
    c0 = cyc;
    ireq = 1'b1; icache_addr = 32'h100;
    exp_gnt(32'h100, 1'b0, 32'h0, c0 + 1);
    exp_rsp(1'b0, 32'hDEAD_BEEF, c0 + 2);
    wait_rdy("post_rst", 1'b0, 20);
    ireq = 1'b0;

    // Contention with both sides racing every grant: D,D,D,D,I twice
    yield = 1'b1;
    icache_addr = 32'h600;
    dcache_addr = 32'h700; dcache_wr = 1'b0; dcache_wdata = 32'hABCD;
    for (int k = 0; k < 10; k++) begin
      if ((k % 5) == 4) begin
        exp_gnt(32'h600, 1'b0, 32'h0, -1);
        exp_rsp(1'b0, 32'h6666_0006, -1);
      end else begin
        exp_gnt(32'h700, 1'b0, 32'hABCD, -1);
        exp_rsp(1'b1, 32'h7777_0007, -1);
      end
    end
    step();
    ireq = 1'b1; dreq = 1'b1;
    wait_done("starve", 10, 200);
    yield = 1'b0;

    // Both held through their rdy cycles: the completing side cannot re-win
    exp_gnt(32'h700, 1'b0, 32'hABCD, -1); exp_rsp(1'b1, 32'h7777_0007, -1);
    exp_gnt(32'h600, 1'b0, 32'h0, -1);    exp_rsp(1'b0, 32'h6666_0006, -1);
    exp_gnt(32'h700, 1'b0, 32'hABCD, -1); exp_rsp(1'b1, 32'h7777_0007, -1);
    exp_gnt(32'h600, 1'b0, 32'h0, -1);    exp_rsp(1'b0, 32'h6666_0006, -1);
    step();
    ireq = 1'b1; dreq = 1'b1;
    wait_done("alternate", 4, 100);

    repeat (4) step();
    chk("grants_drained", 32'(gq.size()), 32'h0);
    chk("rsps_drained", 32'(rq.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares a single unified memory port between the CPU's instruction-fetch (icache) side and its load/store (dcache) side. Sits between the `pipeline` cache interfaces and the external memory, with one transaction outstanding at a time. Data accesses have priority, and a starvation counter guarantees forward progress for fetches. All request parameters are registered at grant, so the memory port sees stable values for the whole transaction.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: consecutive dcache grants allowed while icache waits; legal range 1..15.

Ports:
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `icache_en` in 1: fetch request; held until `icache_rdy`.
- `icache_addr` in 32: fetch address.
- `icache_data` out 32: fetch data; valid in the `icache_rdy` cycle.
- `icache_rdy` out 1: one-cycle completion pulse.
- `dcache_en` in 1: data request; held until `dcache_rdy`.
- `dcache_wr` in 1: 1 = store, 0 = load.
- `dcache_addr` in 32: data address.
- `dcache_wdata` in 32: store data.
- `dcache_rdata` out 32: load data; valid in the `dcache_rdy` cycle.
- `dcache_rdy` out 1: one-cycle completion pulse.
- `mem_en` out 1: memory request active.
- `mem_wr` out 1: memory write.
- `mem_addr` out 32: memory address.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: memory read data; valid when `mem_rdy` = 1.
- `mem_rdy` in 1: memory completion; sampled only while `mem_en` = 1.

## Operation
- FSM states: IDLE, GNT_I, GNT_D.
- In IDLE, the arbiter considers only live requests:
  - A request is live when its `*_en` = 1 and its own `*_rdy` is not high that cycle. A requester still holding `en` in its rdy cycle therefore does not re-win.
- Arbitration in IDLE:
  - Only icache live → GNT_I.
  - Only dcache live → GNT_D.
  - Both live → GNT_D, unless `dstreak` == `STARVE_LIMIT`, in which case → GNT_I.
  - Neither live → stay in IDLE.
- `dstreak` counter:
  - Width 4.
  - Incremented, saturating at `STARVE_LIMIT`, on a GNT_D grant made while icache is live.
  - Cleared on any GNT_I grant.
  - Unchanged on a GNT_D grant made with icache not live.
- At the grant edge, the winner's addr, wdata and wr are captured into `mem_addr`, `mem_wdata` and `mem_wr`. For icache grants, `mem_wr` = 0 and `mem_wdata` = 0.
- In GNT_x, `mem_en` = 1 and the `mem_*` outputs are stable. The FSM stays in GNT_x until `mem_rdy` = 1.
- On the edge where `mem_rdy` = 1 in GNT_x:
  - The FSM returns to IDLE and `mem_en` drops.
  - The owning `*_rdy` is registered high for exactly one cycle.
  - In GNT_I, `icache_data` ← `mem_rdata`.
  - In GNT_D with a load, `dcache_rdata` ← `mem_rdata`. Stores leave `dcache_rdata` unchanged.
- Data outputs hold their last value between transactions.
- If a requester drops `en` mid-transaction, the memory transaction still completes and `rdy` still pulses; the result is simply unused.
- Reset (asynchronous, any state):
  - State → IDLE; `dstreak` = 0.
  - All outputs 0: `mem_en`, `mem_wr`, `mem_addr`, `mem_wdata`, `icache_rdy`, `icache_data`, `dcache_rdy`, `dcache_rdata`.
  - Any in-flight memory transaction is abandoned.

## Timing
- Minimum latency: request live at cycle 0 (IDLE) → `mem_en` at cycle 1 → `mem_rdy` at cycle 1 → `*_rdy` at cycle 2.
- With N memory wait cycles, `*_rdy` rises at cycle 2+N.
- There is one mandatory IDLE cycle between transactions; that cycle coincides with the `rdy` pulse.
- Back-to-back throughput is one transaction per 2+N cycles.
- `icache_rdy` and `dcache_rdy` are never high in the same cycle.
- `mem_en` is never high in IDLE.
- With both sides continuously requesting and `STARVE_LIMIT` = L, the grant pattern is L×D, 1×I, repeating.

## Structure
- Shared package `mem_arb_pkg` holds:
  - The state enum {IDLE, GNT_I, GNT_D} as a 2-bit encoding.
  - The default `STARVE_LIMIT` constant.
  - The `XLEN` = 32 width constant.
- Single module, no sub-modules. The arbitration decision is a small combinational block feeding the FSM register and the capture registers.

## Test plan
- Lone fetch: `icache_en`=1, addr `0x100`, memory returns `0xDEADBEEF` with zero wait → `mem_en` at cycle 1, `mem_addr`=`0x100`, `mem_wr`=0; `icache_rdy`=1 with `icache_data`=`0xDEADBEEF` at cycle 2.
- Store then load: store of `0x55AA` to `0x200` completes and `dcache_rdata` is unchanged. A following load from `0x200` with 3 wait cycles returns `0x55AA`, and `dcache_rdy` arrives 5 cycles after the load became live.
- Contention, L=4: both requesters held continuously → grant sequence D,D,D,D,I,D,D,D,D,I. `dstreak` is 0 after each I grant.
- Held enable: icache keeps `en`=1 through its rdy cycle with dcache idle → no re-grant in the rdy cycle; the next grant starts from the following IDLE cycle.
- Reset mid-transaction: assert `reset` while in GNT_D waiting on memory → all outputs 0 immediately (asynchronously), and no `dcache_rdy` pulse. After release, a fresh fetch completes normally.
- Dropped request: icache deasserts `en` one cycle into GNT_I → the transaction completes, `icache_rdy` still pulses once, and the FSM returns to IDLE.
